// File: rtl/tile_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tile_scheduler_if
// Purpose  : Triangle-in / tile-request-out bundle for the tile scheduler.
// Revision : 1.0
// ============================================================================
interface tile_scheduler_if #(
    parameter int FX_TOTAL_BITS = 16,
    parameter int TILE_IDX_BITS = 8
);
    typedef struct packed {
        logic signed [FX_TOTAL_BITS-1:0] x;
        logic signed [FX_TOTAL_BITS-1:0] y;
        logic signed [FX_TOTAL_BITS-1:0] z;
    } coord_3d_t;

    logic                     vld_in;
    logic                     rdy_in;
    coord_3d_t                v0;
    coord_3d_t                v1;
    coord_3d_t                v2;
    logic [3:0]               in_color;
    logic                     vld_out;
    logic                     rdy_out;
    coord_3d_t                out_v0;
    coord_3d_t                out_v1;
    coord_3d_t                out_v2;
    logic [TILE_IDX_BITS-1:0] out_tile_x;
    logic [TILE_IDX_BITS-1:0] out_tile_y;
    logic [3:0]               out_color;
    logic                     tri_done;
    logic [15:0]              tile_count;

    modport master (
        output vld_in, v0, v1, v2, in_color, rdy_out,
        input  rdy_in, vld_out, out_v0, out_v1, out_v2,
               out_tile_x, out_tile_y, out_color, tri_done, tile_count
    );

    modport slave (
        input  vld_in, v0, v1, v2, in_color, rdy_out,
        output rdy_in, vld_out, out_v0, out_v1, out_v2,
               out_tile_x, out_tile_y, out_color, tri_done, tile_count
    );
endinterface
`default_nettype wire

// File: rtl/tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tile_scheduler
// Purpose  : Bounding-box tile walker; issues one request per covered tile.
// Revision : 1.0
// ============================================================================
module tile_scheduler #(
    parameter int FX_TOTAL_BITS = 16,
    parameter int FX_FRAC_BITS  = 4,
    parameter int TILE_SHIFT    = 5,
    parameter int TILES_X       = 20,
    parameter int TILES_Y       = 15,
    parameter int TILE_IDX_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    tile_scheduler_if.slave  bus
);
    localparam int c_w     = FX_TOTAL_BITS;
    localparam int c_ext_w = FX_TOTAL_BITS + 1;
    localparam int c_shamt = FX_FRAC_BITS + TILE_SHIFT;
    localparam logic signed [c_ext_w-1:0] c_last_tx = c_ext_w'(TILES_X - 1);
    localparam logic signed [c_ext_w-1:0] c_last_ty = c_ext_w'(TILES_Y - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BBOX  = 3'd1,
        CLAMP = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3*c_w-1:0]           r_v [3];
    logic [3:0]                 r_color;
    logic signed [c_ext_w-1:0]  r_min_tx, r_max_tx, r_min_ty, r_max_ty;
    logic [TILE_IDX_BITS-1:0]   r_lo_x, r_hi_x, r_hi_y;
    logic [TILE_IDX_BITS-1:0]   r_cur_x, r_cur_y;
    logic [15:0]                r_tile_count;
    logic                       r_rdy_in, r_vld_out, r_tri_done;

    logic signed [c_ext_w-1:0]  w_x [3];
    logic signed [c_ext_w-1:0]  w_y [3];
    logic signed [c_ext_w-1:0]  w_min_tx, w_max_tx, w_min_ty, w_max_ty;
    logic [TILE_IDX_BITS-1:0]   w_lo_x, w_hi_x, w_lo_y, w_hi_y;
    logic                       w_cull, w_fire, w_last;

    function automatic logic signed [c_ext_w-1:0] min3(
        input logic signed [c_ext_w-1:0] a, b, c);
        logic signed [c_ext_w-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [c_ext_w-1:0] max3(
        input logic signed [c_ext_w-1:0] a, b, c);
        logic signed [c_ext_w-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Sign-extend one bit before the min/max so extreme coordinates never wrap.
    for (genvar i = 0; i < 3; i++) begin : g_ext
        assign w_x[i] = c_ext_w'($signed(r_v[i][3*c_w-1 -: c_w]));
        assign w_y[i] = c_ext_w'($signed(r_v[i][2*c_w-1 -: c_w]));
    end

    assign w_min_tx = min3(w_x[0], w_x[1], w_x[2]) >>> c_shamt;
    assign w_max_tx = max3(w_x[0], w_x[1], w_x[2]) >>> c_shamt;
    assign w_min_ty = min3(w_y[0], w_y[1], w_y[2]) >>> c_shamt;
    assign w_max_ty = max3(w_y[0], w_y[1], w_y[2]) >>> c_shamt;

    assign w_cull = r_max_tx[c_ext_w-1] || r_max_ty[c_ext_w-1] ||
                    (r_min_tx > c_last_tx) || (r_min_ty > c_last_ty);

    assign w_lo_x = r_min_tx[c_ext_w-1] ? '0 : r_min_tx[TILE_IDX_BITS-1:0];
    assign w_lo_y = r_min_ty[c_ext_w-1] ? '0 : r_min_ty[TILE_IDX_BITS-1:0];
    assign w_hi_x = (r_max_tx > c_last_tx) ? c_last_tx[TILE_IDX_BITS-1:0]
                                           : r_max_tx[TILE_IDX_BITS-1:0];
    assign w_hi_y = (r_max_ty > c_last_ty) ? c_last_ty[TILE_IDX_BITS-1:0]
                                           : r_max_ty[TILE_IDX_BITS-1:0];

    assign w_fire = (r_state == ISSUE) && bus.rdy_out;
    assign w_last = (r_cur_x == r_hi_x) && (r_cur_y == r_hi_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.vld_in) w_state_nxt = BBOX;
            BBOX:    w_state_nxt = CLAMP;
            CLAMP:   w_state_nxt = w_cull ? DONE : ISSUE;
            ISSUE:   if (w_fire && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_in   <= 1'b1;
            r_vld_out  <= 1'b0;
            r_tri_done <= 1'b0;
        end else begin
            r_rdy_in   <= (w_state_nxt == IDLE);
            r_vld_out  <= (w_state_nxt == ISSUE);
            r_tri_done <= (w_state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v[0]       <= '0;
            r_v[1]       <= '0;
            r_v[2]       <= '0;
            r_color      <= '0;
            r_min_tx     <= '0;
            r_max_tx     <= '0;
            r_min_ty     <= '0;
            r_max_ty     <= '0;
            r_lo_x       <= '0;
            r_hi_x       <= '0;
            r_hi_y       <= '0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_tile_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.vld_in) begin
                        r_v[0]       <= bus.v0;
                        r_v[1]       <= bus.v1;
                        r_v[2]       <= bus.v2;
                        r_color      <= bus.in_color;
                        r_tile_count <= '0;
                    end
                end
                BBOX: begin
                    r_min_tx <= w_min_tx;
                    r_max_tx <= w_max_tx;
                    r_min_ty <= w_min_ty;
                    r_max_ty <= w_max_ty;
                end
                CLAMP: begin
                    r_lo_x  <= w_lo_x;
                    r_hi_x  <= w_hi_x;
                    r_hi_y  <= w_hi_y;
                    r_cur_x <= w_lo_x;
                    r_cur_y <= w_lo_y;
                end
                ISSUE: begin
                    if (w_fire) begin
                        r_tile_count <= r_tile_count + 1'b1;
                        if (r_cur_x != r_hi_x) begin
                            r_cur_x <= r_cur_x + 1'b1;
                        end else if (r_cur_y != r_hi_y) begin
                            r_cur_x <= r_lo_x;
                            r_cur_y <= r_cur_y + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy_in     = r_rdy_in;
    assign bus.vld_out    = r_vld_out;
    assign bus.tri_done   = r_tri_done;
    assign bus.out_v0     = r_v[0];
    assign bus.out_v1     = r_v[1];
    assign bus.out_v2     = r_v[2];
    assign bus.out_color  = r_color;
    assign bus.out_tile_x = r_cur_x;
    assign bus.out_tile_y = r_cur_y;
    assign bus.tile_count = r_tile_count;
endmodule
`default_nettype wire

// File: tb/tb_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_scheduler
// Purpose  : Scoreboard bench for tile_scheduler with a floor-division model.
// Revision : 1.0
// ============================================================================
module tb_tile_scheduler;
    localparam int c_tx  = 20;
    localparam int c_ty  = 15;
    localparam int c_tsz = 512;   // tile edge in raw 12.4 units

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_scheduler_if #(.FX_TOTAL_BITS(16), .TILE_IDX_BITS(8)) bus ();

    tile_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          tx;
        int          ty;
        logic [3:0]  col;
        logic [47:0] v0, v1, v2;
    } exp_t;

    exp_t tile_q[$];
    int   done_q[$];
    exp_t e_head;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    bit   mon_en = 1'b1;

    function automatic int fdiv(input int a);
        return (a >= 0) ? a / c_tsz : -((-a + c_tsz - 1) / c_tsz);
    endfunction

    function automatic logic [47:0] mk(input int x, input int y, input int z);
        return {16'(x), 16'(y), 16'(z)};
    endfunction

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enumerate covered, screen-clipped tiles directly from the bounding box.
    task automatic model(input int xs[3], input int ys[3], input logic [3:0] col,
                         input logic [47:0] a, b, c, output int n);
        int lx, hx, ly, hy;
        exp_t t;
        lx = fdiv(imin(xs[0], imin(xs[1], xs[2])));
        hx = fdiv(imax(xs[0], imax(xs[1], xs[2])));
        ly = fdiv(imin(ys[0], imin(ys[1], ys[2])));
        hy = fdiv(imax(ys[0], imax(ys[1], ys[2])));
        n = 0;
        if (!(hx < 0 || hy < 0 || lx > c_tx - 1 || ly > c_ty - 1)) begin
            lx = imax(lx, 0); ly = imax(ly, 0);
            hx = imin(hx, c_tx - 1); hy = imin(hy, c_ty - 1);
            for (int y = ly; y <= hy; y++)
                for (int x = lx; x <= hx; x++) begin
                    t.tx = x; t.ty = y; t.col = col; t.v0 = a; t.v1 = b; t.v2 = c;
                    tile_q.push_back(t);
                    n++;
                end
        end
        done_q.push_back(n);
    endtask

    task automatic send(input int x0, y0, x1, y1, x2, y2, input logic [3:0] col);
        int n, ntiles;
        int xs[3], ys[3];
        logic [47:0] a, b, c;
        logic [63:0] rnd;
        a = mk(x0, y0, int'($urandom_range(0, 65535)));
        b = mk(x1, y1, int'($urandom_range(0, 65535)));
        c = mk(x2, y2, int'($urandom_range(0, 65535)));
        xs = '{x0, x1, x2};
        ys = '{y0, y1, y2};
        n = 0;
        while (!bus.rdy_in && n < 1000) begin @(posedge clk); #1; n++; end
        chk("rdy_in_idle", bus.rdy_in, 1);
        model(xs, ys, col, a, b, c, ntiles);
        bus.v0 = a; bus.v1 = b; bus.v2 = c; bus.in_color = col; bus.vld_in = 1'b1;
        @(posedge clk); #1;
        bus.vld_in = 1'b0;
        rnd = {$urandom(), $urandom()}; bus.v0 = rnd[47:0];
        rnd = {$urandom(), $urandom()}; bus.v1 = rnd[47:0];
        bus.in_color = 4'($urandom());
        chk("rdy_in_busy", bus.rdy_in, 0);
        @(posedge clk); #1;
        chk("no_early_out", {bus.vld_out, bus.tri_done}, 2'b00);
        @(posedge clk); #1;
        chk(ntiles == 0 ? "cull_done_lat" : "first_vld_lat",
            {bus.vld_out, bus.tri_done}, ntiles == 0 ? 2'b01 : 2'b10);
        n = 0;
        while (!bus.tri_done && n < 5000) begin @(posedge clk); #1; n++; end
        chk("tri_done_seen", bus.tri_done, 1);
        if (rdy_mode == 1) chk("burst_cycles", n, ntiles);
        @(posedge clk); #1;
        chk("done_one_cycle", bus.tri_done, 0);
        chk("rdy_in_after", bus.rdy_in, 1);
    endtask

    initial begin
        bus.rdy_out = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.rdy_out = 1'($urandom_range(0, 1));
                1:       bus.rdy_out = 1'b1;
                default: bus.rdy_out = ~bus.rdy_out;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (bus.vld_out) begin
                if (tile_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_tile: got (%0d,%0d) expected none",
                             bus.out_tile_x, bus.out_tile_y);
                end else begin
                    e_head = tile_q[0];
                    chk("tile_x", bus.out_tile_x, e_head.tx);
                    chk("tile_y", bus.out_tile_y, e_head.ty);
                    chk("color", bus.out_color, e_head.col);
                    chk("out_v0", bus.out_v0, e_head.v0);
                    chk("out_v1", bus.out_v1, e_head.v1);
                    chk("out_v2", bus.out_v2, e_head.v2);
                    if (bus.rdy_out) void'(tile_q.pop_front());
                end
            end
            if (bus.tri_done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_done: got tri_done expected none");
                end else begin
                    chk("tile_count", bus.tile_count, done_q.pop_front());
                    chk("missing_tiles", tile_q.size(), 0);
                end
            end
        end
    end

    initial begin
        int cx, cy;
        rst = 1'b1;
        bus.vld_in = 1'b0; bus.v0 = '0; bus.v1 = '0; bus.v2 = '0; bus.in_color = '0;
        #1;
        chk("rst_rdy_in", bus.rdy_in, 1);
        chk("rst_vld_out", bus.vld_out, 0);
        chk("rst_tri_done", bus.tri_done, 0);
        chk("rst_tile_xy", {bus.out_tile_x, bus.out_tile_y}, 0);
        chk("rst_color", bus.out_color, 0);
        chk("rst_tile_count", bus.tile_count, 0);
        chk("rst_out_v0", bus.out_v0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        rdy_mode = 1;
        send(160, 160, 320, 160, 160, 320, 4'h3);
        send(160, 160, 640, 160, 160, 640, 4'hA);
        rdy_mode = 2;
        send(160, 160, 640, 160, 160, 640, 4'h5);
        rdy_mode = 1;
        send(-800, -800, 320, -640, 160, 320, 4'h7);
        send(11200, 160, 11520, 160, 11360, 480, 4'h1);
        send(9600, 7360, 10224, 7520, 9920, 7664, 4'hC);
        rdy_mode = 0;
        send(-1600, -1600, 12800, -1600, -1600, 11200, 4'hF);
        send(4000, 4000, 4000, 4000, 4000, 4000, 4'h2);

        // Reset in the middle of a 2x2 scan, then resume from IDLE.
        rdy_mode = 1;
        mon_en = 1'b0;
        bus.v0 = mk(160, 160, 0); bus.v1 = mk(640, 160, 0); bus.v2 = mk(160, 640, 0);
        bus.in_color = 4'h9; bus.vld_in = 1'b1;
        @(posedge clk); #1;
        bus.vld_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_tile_x", bus.out_tile_x, 1);
        chk("pre_rst_vld", bus.vld_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_vld", bus.vld_out, 0);
        chk("rst_count_clr", bus.tile_count, 0);
        @(posedge clk); #1;
        chk("rst_no_done", bus.tri_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy_in", bus.rdy_in, 1);
        tile_q.delete();
        done_q.delete();
        mon_en = 1'b1;
        send(160, 160, 640, 160, 160, 640, 4'h6);

        rdy_mode = 0;
        for (int i = 0; i < 25; i++) begin
            cx = int'($urandom_range(0, 940)) - 150;
            cy = int'($urandom_range(0, 780)) - 150;
            send((cx + int'($urandom_range(0, 120)) - 60) * 16 + int'($urandom_range(0, 15)),
                 (cy + int'($urandom_range(0, 120)) - 60) * 16 + int'($urandom_range(0, 15)),
                 (cx + int'($urandom_range(0, 120)) - 60) * 16 + int'($urandom_range(0, 15)),
                 (cy + int'($urandom_range(0, 120)) - 60) * 16 + int'($urandom_range(0, 15)),
                 (cx + int'($urandom_range(0, 120)) - 60) * 16 + int'($urandom_range(0, 15)),
                 (cy + int'($urandom_range(0, 120)) - 60) * 16 + int'($urandom_range(0, 15)),
                 4'($urandom()));
        end

        repeat (3) @(posedge clk);
        chk("final_tile_q_empty", tile_q.size(), 0);
        chk("final_done_q_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
